// File: rtl/trap_csr.sv
// Trap CSR unit: M/S trap CSRs, privilege tracking, trap entry and xret handling,
// plus registered selection of the highest-priority enabled interrupt.
module trap_csr (
  input  logic         clk,
  input  logic         rst,
  input  logic [38:0]  IN_trapInfo,
  input  logic [1:0]   IN_xret,
  input  logic [45:0]  IN_csrReq,
  output logic         OUT_csrReady,
  output logic [33:0]  OUT_csrResp,
  input  logic         IN_meip,
  input  logic         IN_mtip,
  input  logic         IN_msip,
  input  logic         IN_seip,
  output logic [130:0] OUT_trapControl
);
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [11:0] ADDR_SSTATUS  = 12'h100;
  localparam logic [11:0] ADDR_STVEC    = 12'h105;
  localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
  localparam logic [11:0] ADDR_SEPC     = 12'h141;
  localparam logic [11:0] ADDR_SCAUSE   = 12'h142;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MEDELEG  = 12'h302;
  localparam logic [11:0] ADDR_MIDELEG  = 12'h303;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  logic        trapValid, trapDelegate, trapIsInt;
  logic [31:0] trapPC;
  logic [3:0]  trapCause;
  logic        xretValid, xretIsMret;
  logic        reqValid, reqWrite;
  logic [11:0] reqAddr;
  logic [31:0] reqWdata;

  assign {trapValid, trapPC, trapCause, trapDelegate, trapIsInt} = IN_trapInfo;
  assign {xretValid, xretIsMret} = IN_xret;
  assign {reqValid, reqWrite, reqAddr, reqWdata} = IN_csrReq;

  logic [1:0]  priv;
  logic        stSie, stMie, stSpie, stMpie, stSpp;
  logic [1:0]  stMpp;
  logic [11:0] mieReg;
  logic        ssip, stip;
  logic [15:0] medeleg, mideleg;
  logic [31:0] mtvec, stvec, mepc, sepc, mcause, scause, mscratch, sscratch;

  logic [31:0] mstatusVal, sstatusVal;
  logic [11:0] mipVal;

  always_comb begin
    mstatusVal        = '0;
    mstatusVal[1]     = stSie;
    mstatusVal[3]     = stMie;
    mstatusVal[5]     = stSpie;
    mstatusVal[7]     = stMpie;
    mstatusVal[8]     = stSpp;
    mstatusVal[12:11] = stMpp;
    sstatusVal        = '0;
    sstatusVal[1]     = stSie;
    sstatusVal[5]     = stSpie;
    sstatusVal[8]     = stSpp;
    mipVal            = '0;
    mipVal[11]        = IN_meip;
    mipVal[9]         = IN_seip;
    mipVal[7]         = IN_mtip;
    mipVal[5]         = stip;
    mipVal[3]         = IN_msip;
    mipVal[1]         = ssip;
  end

  logic        implemented;
  logic [31:0] readVal;

  always_comb begin
    implemented = 1'b1;
    readVal     = '0;
    case (reqAddr)
      ADDR_SSTATUS:  readVal = sstatusVal;
      ADDR_STVEC:    readVal = stvec;
      ADDR_SSCRATCH: readVal = sscratch;
      ADDR_SEPC:     readVal = sepc;
      ADDR_SCAUSE:   readVal = scause;
      ADDR_MSTATUS:  readVal = mstatusVal;
      ADDR_MEDELEG:  readVal = {16'b0, medeleg};
      ADDR_MIDELEG:  readVal = {16'b0, mideleg};
      ADDR_MIE:      readVal = {20'b0, mieReg};
      ADDR_MTVEC:    readVal = mtvec;
      ADDR_MSCRATCH: readVal = mscratch;
      ADDR_MEPC:     readVal = mepc;
      ADDR_MCAUSE:   readVal = mcause;
      ADDR_MIP:      readVal = {20'b0, mipVal};
      default:       implemented = 1'b0;
    endcase
  end

  logic illegal, accept, doWrite;
  assign illegal      = ~implemented | (priv < reqAddr[9:8]) | (reqWrite & (reqAddr[11:10] == 2'b11));
  assign OUT_csrReady = rst & ~trapValid & ~xretValid;
  assign accept       = reqValid & OUT_csrReady;
  assign doWrite      = accept & reqWrite & ~illegal;

  // Trap entry wins over xret; CSR writes can only land when neither is active.
  always_ff @(posedge clk) begin
    if (!rst) begin
      priv     <= PRIV_M;
      stSie    <= 1'b0;
      stMie    <= 1'b0;
      stSpie   <= 1'b0;
      stMpie   <= 1'b0;
      stSpp    <= 1'b0;
      stMpp    <= PRIV_U;
      mieReg   <= '0;
      ssip     <= 1'b0;
      stip     <= 1'b0;
      medeleg  <= '0;
      mideleg  <= '0;
      mtvec    <= '0;
      stvec    <= '0;
      mepc     <= '0;
      sepc     <= '0;
      mcause   <= '0;
      scause   <= '0;
      mscratch <= '0;
      sscratch <= '0;
    end else if (trapValid) begin
      if (trapDelegate) begin
        sepc   <= trapPC;
        scause <= {trapIsInt, 27'b0, trapCause};
        stSpie <= stSie;
        stSie  <= 1'b0;
        stSpp  <= priv[0];
        priv   <= PRIV_S;
      end else begin
        mepc   <= trapPC;
        mcause <= {trapIsInt, 27'b0, trapCause};
        stMpie <= stMie;
        stMie  <= 1'b0;
        stMpp  <= priv;
        priv   <= PRIV_M;
      end
    end else if (xretValid) begin
      if (xretIsMret) begin
        priv   <= stMpp;
        stMie  <= stMpie;
        stMpie <= 1'b1;
        stMpp  <= PRIV_U;
      end else begin
        priv   <= {1'b0, stSpp};
        stSie  <= stSpie;
        stSpie <= 1'b1;
        stSpp  <= 1'b0;
      end
    end else if (doWrite) begin
      case (reqAddr)
        ADDR_SSTATUS: begin
          stSie  <= reqWdata[1];
          stSpie <= reqWdata[5];
          stSpp  <= reqWdata[8];
        end
        ADDR_MSTATUS: begin
          stSie  <= reqWdata[1];
          stMie  <= reqWdata[3];
          stSpie <= reqWdata[5];
          stMpie <= reqWdata[7];
          stSpp  <= reqWdata[8];
          stMpp  <= (reqWdata[12:11] == 2'b10) ? PRIV_U : reqWdata[12:11];
        end
        ADDR_STVEC:    stvec    <= {reqWdata[31:2], 2'b00};
        ADDR_MTVEC:    mtvec    <= {reqWdata[31:2], 2'b00};
        ADDR_SEPC:     sepc     <= {reqWdata[31:1], 1'b0};
        ADDR_MEPC:     mepc     <= {reqWdata[31:1], 1'b0};
        ADDR_SCAUSE:   scause   <= {reqWdata[31], 27'b0, reqWdata[3:0]};
        ADDR_MCAUSE:   mcause   <= {reqWdata[31], 27'b0, reqWdata[3:0]};
        ADDR_SSCRATCH: sscratch <= reqWdata;
        ADDR_MSCRATCH: mscratch <= reqWdata;
        ADDR_MEDELEG:  medeleg  <= reqWdata[15:0] & 16'hF7FF;
        ADDR_MIDELEG:  mideleg  <= reqWdata[15:0] & 16'h0222;
        ADDR_MIE:      mieReg   <= reqWdata[11:0] & 12'hAAA;
        ADDR_MIP: begin
          ssip <= reqWdata[1];
          stip <= reqWdata[5];
        end
        default: ;
      endcase
    end
  end

  logic        respValid, respIllegal;
  logic [31:0] respData;

  always_ff @(posedge clk) begin
    if (!rst) begin
      respValid   <= 1'b0;
      respIllegal <= 1'b0;
      respData    <= '0;
    end else begin
      respValid   <= accept;
      respIllegal <= accept & illegal;
      respData    <= (accept & ~illegal) ? readVal : '0;
    end
  end

  logic        mLevelOn, sLevelOn, anyNext, delegNext;
  logic [11:0] pendingBits, enabledBits;
  logic [3:0]  causeNext;

  assign mLevelOn = (priv != PRIV_M) | stMie;
  assign sLevelOn = (priv == PRIV_U) | ((priv == PRIV_S) & stSie);

  always_comb begin
    pendingBits = mipVal & mieReg;
    enabledBits = '0;
    for (int unsigned i = 0; i < 12; i++)
      enabledBits[i] = pendingBits[i] & (mideleg[i] ? sLevelOn : mLevelOn);
    anyNext   = 1'b1;
    causeNext = 4'd0;
    if (enabledBits[11])     causeNext = 4'd11;
    else if (enabledBits[3]) causeNext = 4'd3;
    else if (enabledBits[7]) causeNext = 4'd7;
    else if (enabledBits[9]) causeNext = 4'd9;
    else if (enabledBits[1]) causeNext = 4'd1;
    else if (enabledBits[5]) causeNext = 4'd5;
    else                     anyNext   = 1'b0;
    delegNext = anyNext & mideleg[causeNext];
  end

  logic       intPending, intDelegate;
  logic [3:0] intCause;

  // Cleared after a trap so the core does not re-take the interrupt just entered.
  always_ff @(posedge clk) begin
    if (!rst || trapValid) begin
      intPending  <= 1'b0;
      intCause    <= '0;
      intDelegate <= 1'b0;
    end else begin
      intPending  <= anyNext;
      intCause    <= causeNext;
      intDelegate <= delegNext;
    end
  end

  logic [30:0] retvec;
  assign retvec = (priv == PRIV_M) ? mepc[31:1] : sepc[31:1];

  assign OUT_csrResp     = {respValid, respIllegal, respData};
  assign OUT_trapControl = {priv, mtvec[31:2], stvec[31:2], retvec, medeleg, mideleg,
                            intPending, intCause, intDelegate};
endmodule

// File: tb/tb_trap_csr.sv
// Self-checking bench for trap_csr: CSR responses go through a scoreboard queue,
// trap-control outputs are compared against hand-derived constants.
module tb_trap_csr;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [38:0]  trapInfo = '0;
  logic [1:0]   xret = '0;
  logic [45:0]  csrReq = '0;
  logic         csrReady;
  logic [33:0]  csrResp;
  logic         meip = 1'b0, mtip = 1'b0, msip = 1'b0, seip = 1'b0;
  logic [130:0] tc;

  trap_csr dut (
    .clk(clk), .rst(rst), .IN_trapInfo(trapInfo), .IN_xret(xret), .IN_csrReq(csrReq),
    .OUT_csrReady(csrReady), .OUT_csrResp(csrResp), .IN_meip(meip), .IN_mtip(mtip),
    .IN_msip(msip), .IN_seip(seip), .OUT_trapControl(tc)
  );

  always #5 clk = ~clk;

  logic [1:0]  tcPriv;
  logic [29:0] tcMtvec, tcStvec;
  logic [30:0] tcRetvec;
  logic [15:0] tcMedeleg, tcMideleg;
  logic        tcPend, tcDeleg;
  logic [3:0]  tcCause;
  assign {tcPriv, tcMtvec, tcStvec, tcRetvec, tcMedeleg, tcMideleg, tcPend, tcCause, tcDeleg} = tc;

  typedef struct {
    string       tag;
    logic        ill;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic csr(input string tag, input logic wr, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic ill, input logic [31:0] rd);
    exp_t e;
    @(negedge clk);
    csrReq = {1'b1, wr, addr, wdata};
    #1;
    check({tag, "/ready"}, csrReady, 1);
    if (csrReady) begin
      e.tag = tag; e.ill = ill; e.data = rd;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1 csrReq = '0;
  endtask

  task automatic pulse(input string tag, input logic [38:0] ti, input logic [1:0] xr);
    @(negedge clk);
    trapInfo = ti;
    xret     = xr;
    #1;
    check({tag, "/readyLow"}, csrReady, 0);
    @(posedge clk);
    #1;
    trapInfo = '0;
    xret     = '0;
  endtask

  task automatic checkIrq(input string tag, input logic p, input logic [3:0] c, input logic d);
    check({tag, "/pending"}, tcPend, p);
    check({tag, "/cause"}, tcCause, c);
    check({tag, "/delegate"}, tcDeleg, d);
  endtask

  function automatic logic [38:0] mkTrap(input logic [31:0] pc, input logic [3:0] cause,
                                         input logic deleg, input logic isInt);
    return {1'b1, pc, cause, deleg, isInt};
  endfunction

  // Response monitor: every response must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (csrResp[33] === 1'b1) begin
      if (expQ.size() == 0) check("spuriousResp", 1, 0);
      else begin
        exp_t e;
        e = expQ.pop_front();
        check({e.tag, "/illegal"}, csrResp[32], e.ill);
        check({e.tag, "/rdata"}, csrResp[31:0], e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    csrReq = {1'b1, 1'b0, 12'h305, 32'h0};
    #1 check("rst/ready", csrReady, 0);
    tick(); tick();
    check("rst/respValid", csrResp[33], 0);
    check("rst/priv", tcPriv, 2'd3);
    check("rst/mtvec", tcMtvec, 0);
    check("rst/retvec", tcRetvec, 0);
    checkIrq("rst", 0, 0, 0);
    csrReq = '0;
    rst    = 1'b1;

    csr("wMtvec", 1, 12'h305, 32'h8000_0103, 0, 32'h0);
    csr("rMtvec", 0, 12'h305, 32'h0, 0, 32'h8000_0100);
    check("mtvecOut", tcMtvec, 30'h2000_0040);
    csr("wStvec", 1, 12'h105, 32'h0000_0FFF, 0, 32'h0);
    csr("rStvec", 0, 12'h105, 32'h0, 0, 32'h0000_0FFC);
    check("stvecOut", tcStvec, 30'h3FF);
    csr("wMepc", 1, 12'h341, 32'h0000_1235, 0, 32'h0);
    csr("rMepc", 0, 12'h341, 32'h0, 0, 32'h0000_1234);
    check("retvecM", tcRetvec, 31'h91A);
    csr("wMcause", 1, 12'h342, 32'hFFFF_FFFF, 0, 32'h0);
    csr("rMcause", 0, 12'h342, 32'h0, 0, 32'h8000_000F);
    csr("wMedeleg", 1, 12'h302, 32'hFFFF_FFFF, 0, 32'h0);
    csr("rMedeleg", 0, 12'h302, 32'h0, 0, 32'h0000_F7FF);
    check("medelegOut", tcMedeleg, 16'hF7FF);
    csr("wF11", 1, 12'hF11, 32'h1, 1, 32'h0);
    csr("rF11", 0, 12'hF11, 32'h0, 1, 32'h0);
    csr("wMscratch", 1, 12'h340, 32'hDEAD_BEEF, 0, 32'h0);
    csr("rMscratch", 0, 12'h340, 32'h0, 0, 32'hDEAD_BEEF);
    csr("wSscratch", 1, 12'h140, 32'h1234_5678, 0, 32'h0);
    csr("rSscratch", 0, 12'h140, 32'h0, 0, 32'h1234_5678);

    csr("wMstatusMpp10", 1, 12'h300, 32'h0000_1000, 0, 32'h0);
    csr("rMstatusMpp10", 0, 12'h300, 32'h0, 0, 32'h0);
    csr("wMstatusAll", 1, 12'h300, 32'hFFFF_FFFF, 0, 32'h0);
    csr("rMstatusAll", 0, 12'h300, 32'h0, 0, 32'h0000_19AA);
    csr("rSstatusView", 0, 12'h100, 32'h0, 0, 32'h0000_0122);
    csr("wMstatus", 1, 12'h300, 32'h0000_1888, 0, 32'h0000_19AA);
    csr("rMstatus", 0, 12'h300, 32'h0, 0, 32'h0000_1888);

    csr("wMieMtie", 1, 12'h304, 32'h0000_0080, 0, 32'h0);
    tick(); mtip = 1'b1; tick();
    checkIrq("mtip", 1, 4'd7, 0);
    csr("rMipMtip", 0, 12'h344, 32'h0, 0, 32'h0000_0080);
    tick(); mtip = 1'b0; tick();
    checkIrq("mtipLow", 0, 0, 0);

    csr("wMieAll", 1, 12'h304, 32'hFFFF_FFFF, 0, 32'h0000_0080);
    csr("rMieAll", 0, 12'h304, 32'h0, 0, 32'h0000_0AAA);
    tick(); meip = 1'b1; mtip = 1'b1; msip = 1'b1; tick();
    checkIrq("prio11", 1, 4'd11, 0);
    meip = 1'b0; tick();
    checkIrq("prio3", 1, 4'd3, 0);
    msip = 1'b0; tick();
    checkIrq("prio7", 1, 4'd7, 0);
    seip = 1'b1; tick();
    checkIrq("prio7over9", 1, 4'd7, 0);
    mtip = 1'b0; tick();
    checkIrq("prio9", 1, 4'd9, 0);
    csr("rMipSeip", 0, 12'h344, 32'h0, 0, 32'h0000_0200);
    tick(); seip = 1'b0; tick();
    checkIrq("allLow", 0, 0, 0);

    csr("wMidelegAll", 1, 12'h303, 32'hFFFF_FFFF, 0, 32'h0);
    csr("rMidelegAll", 0, 12'h303, 32'h0, 0, 32'h0000_0222);
    csr("wMideleg", 1, 12'h303, 32'h0000_0020, 0, 32'h0000_0222);
    check("midelegOut", tcMideleg, 16'h0020);
    csr("wMipAll", 1, 12'h344, 32'hFFFF_FFFF, 0, 32'h0);
    csr("rMipAll", 0, 12'h344, 32'h0, 0, 32'h0000_0022);
    tick();
    checkIrq("ssipM", 1, 4'd1, 0);
    csr("wMipStip", 1, 12'h344, 32'h0000_0020, 0, 32'h0000_0022);
    tick(); tick();
    checkIrq("stipInM", 0, 0, 0);

    csr("wMstatusMppS", 1, 12'h300, 32'h0000_0880, 0, 32'h0000_1888);
    csr("wSepc", 1, 12'h141, 32'h0000_4000, 0, 32'h0);
    pulse("mret", '0, 2'b11);
    tick();
    check("mret/priv", tcPriv, 2'd1);
    check("mret/retvec", tcRetvec, 31'h2000);
    checkIrq("inS", 0, 0, 0);
    csr("rMstatusFromS", 0, 12'h300, 32'h0, 1, 32'h0);
    csr("wMscratchFromS", 1, 12'h340, 32'h0000_FFFF, 1, 32'h0);
    csr("rSstatusS", 0, 12'h100, 32'h0, 0, 32'h0);
    csr("rSepcS", 0, 12'h141, 32'h0, 0, 32'h0000_4000);

    pulse("sret", '0, 2'b10);
    tick();
    check("sret/priv", tcPriv, 2'd0);
    tick();
    checkIrq("stipInU", 1, 4'd5, 1);
    csr("rMstatusFromU", 0, 12'h300, 32'h0, 1, 32'h0);
    csr("wSscratchFromU", 1, 12'h140, 32'h0, 1, 32'h0);

    pulse("trapS", mkTrap(32'h0000_1234, 4'd5, 1'b1, 1'b1), 2'b00);
    tick();
    check("trapS/priv", tcPriv, 2'd1);
    check("trapS/retvec", tcRetvec, 31'h91A);
    checkIrq("trapS/forced", 0, 0, 0);
    tick();
    checkIrq("trapS/after", 0, 0, 0);
    csr("rSepcTrap", 0, 12'h141, 32'h0, 0, 32'h0000_1234);
    csr("rScauseTrap", 0, 12'h142, 32'h0, 0, 32'h8000_0005);
    csr("rSstatusTrap", 0, 12'h100, 32'h0, 0, 32'h0);

    pulse("trapMret", mkTrap(32'h0000_2000, 4'd2, 1'b0, 1'b0), 2'b11);
    tick();
    check("trapMret/priv", tcPriv, 2'd3);
    check("trapMret/retvec", tcRetvec, 31'h1000);
    csr("rMstatusTrapM", 0, 12'h300, 32'h0, 0, 32'h0000_0880);
    csr("rMepcTrapM", 0, 12'h341, 32'h0, 0, 32'h0000_2000);
    csr("rMcauseTrapM", 0, 12'h342, 32'h0, 0, 32'h0000_0002);
    csr("rMscratchKept", 0, 12'h340, 32'h0, 0, 32'hDEAD_BEEF);
    csr("rSscratchKept", 0, 12'h140, 32'h0, 0, 32'h1234_5678);

    tick(); mtip = 1'b1; tick(); tick();
    checkIrq("mtipMieOff", 0, 0, 0);
    csr("wMstatusMieOn", 1, 12'h300, 32'h0000_0888, 0, 32'h0000_0880);
    tick(); tick();
    checkIrq("mtipMieOn", 1, 4'd7, 0);
    mtip = 1'b0;

    tick();
    rst    = 1'b0;
    csrReq = {1'b1, 1'b0, 12'h341, 32'h0};
    #1 check("rst2/ready", csrReady, 0);
    tick(); tick();
    check("rst2/priv", tcPriv, 2'd3);
    check("rst2/mtvec", tcMtvec, 0);
    check("rst2/mideleg", tcMideleg, 0);
    checkIrq("rst2", 0, 0, 0);
    csrReq = '0;
    rst    = 1'b1;
    csr("rMtvecAfterRst", 0, 12'h305, 32'h0, 0, 32'h0);
    csr("rMepcAfterRst", 0, 12'h341, 32'h0, 0, 32'h0);

    tick(); tick();
    check("drain", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
